maze_stepper: RTL and testbench
===============================

MAZE_STEPPER -- requirements
Module: maze_stepper

Interface
REQ-001 Parameter GRID_W, default 8, grid columns (>=2).
REQ-002 Parameter GRID_H, default 8, grid rows (>=2).
REQ-003 Parameter TICK_DIV, default 25000000, clock cycles per movement tick (>=2).
REQ-004 Parameter MAX_STEPS, default 255, step budget before lose (>=1).
REQ-005 Parameter START_IDX, default 0, start cell index; must be < GRID_W*GRID_H.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 resetn  in  1  synchronous, active-low reset.
REQ-008 ld  in  1  load maps, restart game.
REQ-009 wall_in  in  GRID_W*GRID_H  wall map, bit=1 impassable.
REQ-010 goal_in  in  GRID_W*GRID_H  goal map.
REQ-011 haz_in  in  GRID_W*GRID_H  hazard map.
REQ-012 dir  in  4  one-hot move request: 1=up, 2=right, 4=down, 8=left.
REQ-013 wall_out, goal_out, haz_out  out  GRID_W*GRID_H each  registered map copies.
REQ-014 pos_map  out  GRID_W*GRID_H  one-hot current position.
REQ-015 pos_x  out  $clog2(GRID_W); pos_y  out  $clog2(GRID_H)  position coordinates.
REQ-016 steps  out  $clog2(MAX_STEPS+1)  steps taken.
REQ-017 tick  out  1  one-cycle movement strobe.
REQ-018 win, lose  out  1 each  level outputs, game result.

Function
REQ-019 Cell index SHALL be y*GRID_W+x; pos_map SHALL be 1<<index.
REQ-020 Tick counter SHALL count down from TICK_DIV-1 to 0, assert tick for the cycle it reads 0, reload TICK_DIV-1 next cycle; it runs in every state.
REQ-021 FSM states: IDLE, PLAY, WIN, LOSE.
REQ-022 ld in any state SHALL, next cycle: latch all three maps, set position to START_IDX, clear steps, enter PLAY, reload tick counter.
REQ-023 In IDLE, WIN and LOSE, no movement or step counting SHALL occur.
REQ-024 In PLAY, moves SHALL be evaluated only on a cycle with tick=1 and ld=0.
REQ-025 dir not exactly one-hot (zero or multiple bits) SHALL produce no move and no step.
REQ-026 One-hot dir SHALL compute target: up y-1, down y+1, right x+1, left x-1.
REQ-027 Target on wall cell SHALL leave position unchanged but increment steps (bump counts).
REQ-028 Legal target SHALL update position and increment steps, same cycle edge.
REQ-029 Checks SHALL use the new position and new step count registered at that tick: hazard -> LOSE; else goal -> WIN; else steps==MAX_STEPS -> LOSE; else stay PLAY.
REQ-030 Hazard and goal on same cell SHALL resolve to LOSE.
REQ-031 win SHALL be 1 iff state==WIN; lose 1 iff state==LOSE; both registered, never simultaneously 1.
REQ-032 steps SHALL saturate at MAX_STEPS.
REQ-033 A START_IDX cell on goal/hazard SHALL not trigger win/lose until the first tick move evaluation.

Reset
REQ-034 resetn=0 at a clock edge SHALL set: state IDLE, maps 0, position START_IDX, steps 0, tick counter TICK_DIV-1, tick 0, win 0, lose 0.
REQ-035 resetn SHALL override ld and any in-progress tick or move.

Configuration
REQ-036 Macro MAZE_STEPPER_WRAP_EN defined: off-edge moves wrap (x GRID_W-1 -> 0, y 0 -> GRID_H-1, etc.), wall check applies to wrapped cell.
REQ-037 Macro undefined: off-edge moves are treated as wall bumps (position held, step counted).

Structure
REQ-038 Shared package maze_pkg SHALL hold the FSM state enum and dir one-hot constants (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT).
REQ-039 Tick counter SHALL be a sub-module tick_divider (parameter TICK_DIV; ports clk, resetn, tick).

Verification (GRID_W=GRID_H=8, TICK_DIV=4, MAX_STEPS=5, START_IDX=0)
REQ-040 Reset then ld with empty maps -> PLAY, pos_map=1, tick every 4th cycle, steps=0.
REQ-041 dir=2 over 3 ticks -> pos_x=3, pos_map=1<<3, steps=3; dir=3 on a tick -> no change.
REQ-042 wall_in bit 1 set, dir=2 on a tick -> pos_x stays 0, steps=1.
REQ-043 dir=8 at x=0: with WRAP_EN -> pos_x=7; without -> pos_x=0, steps=1.
REQ-044 goal_in bit 2 and haz_in bit 2 set, two right moves -> lose=1, win=0; goal-only -> win=1; six blocked bumps -> lose at steps=5.
REQ-045 resetn=0 mid-PLAY at x=4 -> next cycle IDLE, position 0, maps 0, win=lose=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared FSM state type and one-hot move encodings for the maze stepper.
// Define MAZE_STEPPER_WRAP_EN to make off-edge moves wrap around the grid.
package maze_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_e;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

endpackage

// File: rtl/tick_divider.sv
// Free-running down-counter; tick is high for the single cycle it reads zero.
module tick_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/maze_stepper.sv
// Tick-paced maze walker with wall, goal and hazard maps and a step budget.
// Define MAZE_STEPPER_WRAP_EN to wrap off-edge moves instead of bumping.
module maze_stepper
    import maze_pkg::*;
#(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int TICK_DIV  = 25000000,
    parameter int MAX_STEPS = 255,
    parameter int START_IDX = 0
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            ld,
    input  logic [GRID_W*GRID_H-1:0]        wall_in,
    input  logic [GRID_W*GRID_H-1:0]        goal_in,
    input  logic [GRID_W*GRID_H-1:0]        haz_in,
    input  logic [3:0]                      dir,
    output logic [GRID_W*GRID_H-1:0]        wall_out,
    output logic [GRID_W*GRID_H-1:0]        goal_out,
    output logic [GRID_W*GRID_H-1:0]        haz_out,
    output logic [GRID_W*GRID_H-1:0]        pos_map,
    output logic [$clog2(GRID_W)-1:0]       pos_x,
    output logic [$clog2(GRID_H)-1:0]       pos_y,
    output logic [$clog2(MAX_STEPS+1)-1:0]  steps,
    output logic                            tick,
    output logic                            win,
    output logic                            lose
);

    localparam int N  = GRID_W * GRID_H;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = $clog2(N);
    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [XW-1:0] X0   = XW'(START_IDX % GRID_W);
    localparam logic [YW-1:0] Y0   = YW'(START_IDX / GRID_W);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_STEPS);

`ifdef MAZE_STEPPER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [N-1:0]  wall_q, wall_d;
    logic [N-1:0]  goal_q, goal_d;
    logic [N-1:0]  haz_q, haz_d;

    logic [XW-1:0] tx;
    logic [YW-1:0] ty;
    logic          edge_hit;
    logic          valid_dir;
    logic          blocked;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] tgt_idx;
    logic [IW-1:0] new_idx;
    logic [SW-1:0] steps_inc;

    // ld also restarts the movement tick phase
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn & ~ld),
        .tick   (tick)
    );

    always_comb begin
        tx        = pos_x_q;
        ty        = pos_y_q;
        edge_hit  = 1'b0;
        valid_dir = 1'b1;
        unique case (dir)
            DIR_UP: begin
                edge_hit = (pos_y_q == '0);
                ty = edge_hit ? YMAX : pos_y_q - YW'(1);
            end
            DIR_DOWN: begin
                edge_hit = (pos_y_q == YMAX);
                ty = edge_hit ? '0 : pos_y_q + YW'(1);
            end
            DIR_RIGHT: begin
                edge_hit = (pos_x_q == XMAX);
                tx = edge_hit ? '0 : pos_x_q + XW'(1);
            end
            DIR_LEFT: begin
                edge_hit = (pos_x_q == '0);
                tx = edge_hit ? XMAX : pos_x_q - XW'(1);
            end
            default: valid_dir = 1'b0;
        endcase
    end

    assign cur_idx   = IW'(pos_y_q) * IW'(GRID_W) + IW'(pos_x_q);
    assign tgt_idx   = IW'(ty) * IW'(GRID_W) + IW'(tx);
    assign blocked   = (edge_hit & ~WRAP) | wall_q[tgt_idx];
    assign new_idx   = blocked ? cur_idx : tgt_idx;
    assign steps_inc = (steps_q == SMAX) ? steps_q : steps_q + SW'(1);

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        steps_d = steps_q;
        wall_d  = wall_q;
        goal_d  = goal_q;
        haz_d   = haz_q;
        if (ld) begin
            wall_d  = wall_in;
            goal_d  = goal_in;
            haz_d   = haz_in;
            pos_x_d = X0;
            pos_y_d = Y0;
            steps_d = '0;
            state_d = ST_PLAY;
        end else if (state_q == ST_PLAY && tick && valid_dir) begin
            steps_d = steps_inc;
            if (!blocked) begin
                pos_x_d = tx;
                pos_y_d = ty;
            end
            // hazard outranks goal when both mark the landing cell
            if (haz_q[new_idx]) begin
                state_d = ST_LOSE;
            end else if (goal_q[new_idx]) begin
                state_d = ST_WIN;
            end else if (steps_inc == SMAX) begin
                state_d = ST_LOSE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pos_x_q <= X0;
            pos_y_q <= Y0;
            steps_q <= '0;
            wall_q  <= '0;
            goal_q  <= '0;
            haz_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            steps_q <= steps_d;
            wall_q  <= wall_d;
            goal_q  <= goal_d;
            haz_q   <= haz_d;
        end
    end

    assign wall_out = wall_q;
    assign goal_out = goal_q;
    assign haz_out  = haz_q;
    assign pos_map  = N'(1) << cur_idx;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign steps    = steps_q;
    assign win      = (state_q == ST_WIN);
    assign lose     = (state_q == ST_LOSE);

endmodule

// File: tb/tb_maze_stepper.sv
// Scoreboard bench for maze_stepper: a grid-level model predicts each tick.
// Honors MAZE_STEPPER_WRAP_EN in its edge expectations.
module tb_maze_stepper;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TD = 4;
    localparam int MS = 5;
    localparam int N  = W * H;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ld = 1'b0;
    logic [3:0]   dir = 4'd0;
    logic [N-1:0] wall_in = '0;
    logic [N-1:0] goal_in = '0;
    logic [N-1:0] haz_in = '0;
    logic [N-1:0] wall_out, goal_out, haz_out, pos_map;
    logic [2:0]   pos_x, pos_y, steps;
    logic         tick, win, lose;

    always #5 clk = ~clk;

    maze_stepper #(
        .GRID_W(W), .GRID_H(H), .TICK_DIV(TD), .MAX_STEPS(MS), .START_IDX(0)
    ) dut (
        .clk(clk), .resetn(resetn), .ld(ld),
        .wall_in(wall_in), .goal_in(goal_in), .haz_in(haz_in), .dir(dir),
        .wall_out(wall_out), .goal_out(goal_out), .haz_out(haz_out),
        .pos_map(pos_map), .pos_x(pos_x), .pos_y(pos_y), .steps(steps),
        .tick(tick), .win(win), .lose(lose)
    );

    typedef struct {
        int           x;
        int           y;
        int           st;
        bit           w;
        bit           l;
        logic [N-1:0] wm;
        logic [N-1:0] gm;
        logic [N-1:0] hm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 play, 2 win, 3 lose
    int m_state = 0;
    int mx = 0, my = 0, msteps = 0, phase = 0;
    logic [N-1:0] mw = '0, mg = '0, mh = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_move(input logic [3:0] d);
        int dx = 0, dy = 0, nx, ny;
        bit blk = 1'b0;
        case (d)
            4'd1: dy = -1;
            4'd2: dx = 1;
            4'd4: dy = 1;
            4'd8: dx = -1;
            default: return;
        endcase
        nx = mx + dx;
        ny = my + dy;
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
`ifdef MAZE_STEPPER_WRAP_EN
            nx = (nx + W) % W;
            ny = (ny + H) % H;
`else
            blk = 1'b1;
`endif
        end
        if (!blk && mw[ny*W+nx]) blk = 1'b1;
        msteps = (msteps < MS) ? msteps + 1 : MS;
        if (!blk) begin
            mx = nx;
            my = ny;
        end
        if (mh[my*W+mx]) m_state = 3;
        else if (mg[my*W+mx]) m_state = 2;
        else if (msteps == MS) m_state = 3;
    endtask

    task automatic model_edge(input bit l, input bit r, input logic [3:0] d);
        bit tk = (phase == TD - 1);
        if (!r) begin
            m_state = 0; mw = '0; mg = '0; mh = '0;
            mx = 0; my = 0; msteps = 0; phase = 0;
        end else if (l) begin
            m_state = 1; mw = wall_in; mg = goal_in; mh = haz_in;
            mx = 0; my = 0; msteps = 0; phase = 0;
        end else begin
            if (tk) begin
                if (m_state == 1) model_move(d);
                sb.push_back('{x:mx, y:my, st:msteps, w:(m_state == 2),
                               l:(m_state == 3), wm:mw, gm:mg, hm:mh});
            end
            phase = (phase + 1) % TD;
        end
    endtask

    // called at a negedge; returns at the next negedge
    task automatic step(input bit l, input bit r, input logic [3:0] d);
        ld = l;
        resetn = r;
        dir = d;
        model_edge(l, r, d);
        @(negedge clk);
    endtask

    task automatic load(input logic [N-1:0] w, input logic [N-1:0] g, input logic [N-1:0] h);
        wall_in = w;
        goal_in = g;
        haz_in = h;
        step(1'b1, 1'b1, 4'd0);
    endtask

    task automatic run_ticks(input int n, input logic [3:0] d);
        repeat (n * TD) step(1'b0, 1'b1, d);
    endtask

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic load_rand();
        logic [N-1:0] g, h;
        g = rnd64() & rnd64() & rnd64() & rnd64();
        h = rnd64() & rnd64() & rnd64() & rnd64() & rnd64();
        g[0] = 1'b0;
        h[0] = 1'b0;
        load(rnd64() & rnd64(), g, h);
    endtask

    // monitor: every DUT tick that can move is matched to one prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resetn && !ld && tick) begin
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_tick actual=tick required=no_tick");
                end else begin
                    e = sb.pop_front();
                    chk("sb_pos_x", pos_x, e.x);
                    chk("sb_pos_y", pos_y, e.y);
                    chk("sb_pos_map", pos_map, 64'd1 << (e.y * W + e.x));
                    chk("sb_steps", steps, e.st);
                    chk("sb_win", win, e.w);
                    chk("sb_lose", lose, e.l);
                    chk("sb_wall", wall_out, e.wm);
                    chk("sb_goal", goal_out, e.gm);
                    chk("sb_haz", haz_out, e.hm);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_steps", steps, 0);
        chk("rst_pos_map", pos_map, 1);
        chk("rst_pos_x", pos_x, 0);
        chk("rst_pos_y", pos_y, 0);
        chk("rst_wall", wall_out, 0);
        chk("rst_goal", goal_out, 0);
        chk("rst_haz", haz_out, 0);
        chk("rst_tick", tick, 0);

        repeat (6) step(1'b0, 1'b1, 4'd2);
        chk("idle_pos_x", pos_x, 0);
        chk("idle_steps", steps, 0);

        load('0, '0, '0);
        chk("ld_pos_map", pos_map, 1);
        chk("ld_steps", steps, 0);
        chk("ld_win", win, 0);
        chk("ld_lose", lose, 0);

        run_ticks(3, 4'd2);
        chk("right3_pos_x", pos_x, 3);
        chk("right3_pos_map", pos_map, 64'd8);
        chk("right3_steps", steps, 3);
        run_ticks(1, 4'd3);
        chk("multi_pos_x", pos_x, 3);
        chk("multi_steps", steps, 3);

        load(64'h2, '0, '0);
        run_ticks(1, 4'd2);
        chk("wall_pos_x", pos_x, 0);
        chk("wall_steps", steps, 1);

        load('0, '0, '0);
        run_ticks(1, 4'd8);
`ifdef MAZE_STEPPER_WRAP_EN
        chk("edge_pos_x", pos_x, 7);
`else
        chk("edge_pos_x", pos_x, 0);
`endif
        chk("edge_steps", steps, 1);

        load('0, 64'h4, 64'h4);
        run_ticks(2, 4'd2);
        chk("both_lose", lose, 1);
        chk("both_win", win, 0);

        load('0, 64'h4, '0);
        run_ticks(2, 4'd2);
        chk("goal_win", win, 1);
        chk("goal_lose", lose, 0);
        run_ticks(1, 4'd2);
        chk("won_frozen_x", pos_x, 2);

        load(64'h2, '0, '0);
        run_ticks(6, 4'd2);
        chk("budget_lose", lose, 1);
        chk("budget_steps", steps, 5);
        chk("budget_pos_x", pos_x, 0);

        load(64'h8000_0000_0000_0000, 64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000);
        run_ticks(4, 4'd2);
        chk("mid_pos_x", pos_x, 4);
        step(1'b0, 1'b0, 4'd2);
        chk("mrst_pos_map", pos_map, 1);
        chk("mrst_wall", wall_out, 0);
        chk("mrst_goal", goal_out, 0);
        chk("mrst_haz", haz_out, 0);
        chk("mrst_win", win, 0);
        chk("mrst_lose", lose, 0);
        chk("mrst_steps", steps, 0);

        for (int r = 0; r < 30; r++) begin
            load_rand();
            for (int c = 0; c < 160; c++) begin
                logic [3:0] d;
                if ($urandom_range(0, 99) < 80) d = 4'd1 << $urandom_range(0, 3);
                else d = 4'($urandom_range(0, 15));
                wall_in = rnd64();
                goal_in = rnd64();
                haz_in = rnd64();
                if ($urandom_range(0, 39) == 0) load_rand();
                else if ($urandom_range(0, 299) == 0) step(1'b0, 1'b0, d);
                else step(1'b0, 1'b1, d);
            end
        end

        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
